// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port instruction/data memory between the fetch unit
//   (i_ port, read-only) and the load/store unit (d_ port, read/write).
//   Round-robin between the two ports. Only one transaction is outstanding
//   at a time. Memory read latency is fixed at RD_LAT cycles. Byte addresses
//   are converted to word indices. Misaligned accesses never reach memory;
//   they get an error response in the following cycle.
//
// Ports
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   i_req/i_addr    : fetch request and byte address (held until i_gnt)
//   i_gnt           : fetch request accepted this cycle
//   i_rvalid/i_rdata/i_err : fetch response (1-cycle pulse)
//   d_req/d_we/d_addr/d_wdata/d_wmask : data request (held until d_gnt)
//   d_gnt           : data request accepted this cycle
//   d_rvalid/d_rdata/d_err : data read response or misaligned error pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_wmask : memory command
//   mem_rdata       : memory read data, valid RD_LAT cycles after mem_en
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_wmask,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] RBUSY = 1'b1;

  logic [0:0]        state;
  logic [2:0]        cnt;
  logic              last_d;      // 1 when the most recent grant went to the data port
  logic              owner_d;     // owner of the outstanding read
  logic              ierr_vld_p1;
  logic              derr_vld_p1;

  logic              grantable;
  logic              pick_d;
  logic              pick_i;
  logic              any_gnt;
  logic              misal;
  logic              rd_done;
  logic [ADDR_W-1:0] sel_addr;

  always_comb begin
    // The response cycle of a read is also grantable, so reads can issue
    // back-to-back without an idle bubble.
    grantable = (state == IDLE) || ((state == RBUSY) && (cnt == 3'd1));

    // On a conflict the port that did not win last time goes first.
    pick_d    = d_req && (!i_req || !last_d);
    pick_i    = i_req && !pick_d;
    i_gnt     = grantable && pick_i && !reset;
    d_gnt     = grantable && pick_d && !reset;
    any_gnt   = i_gnt || d_gnt;

    sel_addr  = d_gnt ? d_addr : i_addr;
    misal     = (sel_addr[1:0] != 2'b00);

    mem_en    = any_gnt && !misal;
    mem_we    = d_gnt && d_we && !misal;
    mem_addr  = sel_addr[ADDR_W-1:2];
    mem_wdata = d_wdata;
    mem_wmask = d_gnt ? d_wmask : 4'b0000;

    // A read response and a misaligned error response can never coincide:
    // an error grant leaves the arbiter idle, so no read can be maturing
    // in the following cycle.
    rd_done   = (state == RBUSY) && (cnt == 3'd1) && !reset;

    i_rvalid  = (rd_done && !owner_d) || (ierr_vld_p1 && !reset);
    i_err     = ierr_vld_p1 && !reset;
    i_rdata   = (rd_done && !owner_d) ? mem_rdata : '0;

    d_rvalid  = (rd_done && owner_d) || (derr_vld_p1 && !reset);
    d_err     = derr_vld_p1 && !reset;
    d_rdata   = (rd_done && owner_d) ? mem_rdata : '0;
  end

  // grant stage -> response stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      last_d      <= 1'b1;
      owner_d     <= 1'b0;
      ierr_vld_p1 <= 1'b0;
      derr_vld_p1 <= 1'b0;
    end else begin
      ierr_vld_p1 <= i_gnt && misal;
      derr_vld_p1 <= d_gnt && misal;
      if (any_gnt) begin
        last_d <= d_gnt;
      end
      if (mem_en && !mem_we) begin
        state   <= RBUSY;
        cnt     <= 3'(RD_LAT);
        owner_d <= d_gnt;
      end else if (state == RBUSY) begin
        cnt <= cnt - 3'd1;
        if (cnt == 3'd1) begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one shared single-port instruction/data memory between two requesters of the multi-cycle RISC-V core:
  - the fetch unit (i_ port), which only reads;
  - the load/store unit (d_ port), which reads and writes.
- Round-robin arbitration, one outstanding transaction at a time, fixed memory read latency.
- Converts byte addresses to word indices and flags misaligned accesses.

Parameters:
- ADDR_W, 32, byte-address width on requester ports.
- DATA_W, 32, data word width. Fixed at 32; wmask is 4 bits.
- RD_LAT, 1, memory read latency in cycles, from mem_en to valid mem_rdata. Legal range 1..4.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- i_req  input  1  fetch request; held with i_addr until i_gnt.
- i_addr  input  ADDR_W  fetch byte address.
- i_gnt  output  1  fetch request accepted this cycle.
- i_rvalid  output  1  fetch read data valid, 1-cycle pulse.
- i_rdata  output  DATA_W  fetch read data.
- i_err  output  1  misaligned fetch; pulses with i_rvalid.
- d_req  input  1  data request; held with d_we/d_addr/d_wdata/d_wmask until d_gnt.
- d_we  input  1  1=write, 0=read.
- d_addr  input  ADDR_W  data byte address.
- d_wdata  input  DATA_W  write data.
- d_wmask  input  4  byte write enables.
- d_gnt  output  1  data request accepted this cycle.
- d_rvalid  output  1  data read data valid, or write error response; 1-cycle pulse.
- d_rdata  output  DATA_W  data read data.
- d_err  output  1  misaligned data access; pulses with d_rvalid.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write strobe.
- mem_addr  output  ADDR_W-2  word index = addr[ADDR_W-1:2].
- mem_wdata  output  DATA_W  memory write data.
- mem_wmask  output  4  memory byte enables.
- mem_rdata  input  DATA_W  memory read data, valid RD_LAT cycles after mem_en.

Behaviour:

States:
- IDLE: may grant.
- RBUSY: a read is outstanding; a down-counter cnt is loaded with RD_LAT and decremented each cycle.

Grant:
- Grants are combinational, issued in the cycle the request is seen while grantable.
- Grantable means: state is IDLE, or state is RBUSY with cnt==1 (the response cycle), which allows back-to-back reads.
- At most one gnt per cycle.

Arbitration:
- Both requesting: grant the port not recorded in last_gnt.
- One requesting: grant it.
- last_gnt updates on every grant. Reset value is "data", so fetch wins the first conflict.

Memory drive on grant:
- Aligned access: mem_en=1, mem_we=d_we (0 for fetch), mem_addr=addr[ADDR_W-1:2], mem_wdata=d_wdata, mem_wmask=d_wmask.
- Misaligned access (addr[1:0]!=0): mem_en=0, mem_we=0.
- When not granting: mem_en=0, mem_we=0, mem_wmask=0.

Aligned read:
- Go to RBUSY with cnt=RD_LAT, owner registered.
- When cnt==1, the owner's rvalid=1 and rdata=mem_rdata, then return to IDLE unless a new grant occurs the same cycle.
- Latency from gnt to rvalid is exactly RD_LAT cycles.

Aligned write:
- Completes in the grant cycle. No rvalid. State stays or returns to IDLE.

Misaligned access (read or write):
- No memory access.
- The registered response in the next cycle is rvalid=1, err=1, rdata=0.
- Next grant is possible in that response cycle.

Outputs while no response:
- rvalid=0, err=0, rdata=0.

Reset (applies mid-operation too):
- state=IDLE, cnt=0, last_gnt=data.
- All gnt/rvalid/err=0, rdata=0, mem_en=0, mem_we=0.
- An in-flight read is dropped and its rvalid is never issued.

Requester protocol:
- A requester deasserting req before gnt is legal. That request is simply not served.

Test Plan:
- Fetch-only read, RD_LAT=1, i_addr=0x8, mem word[2]=0x00208063 -> i_gnt in cycle 0, mem_addr=2, i_rvalid in cycle 1 with i_rdata=0x00208063, i_err=0.
- Simultaneous i_req and d_req (read), 3 rounds -> grant order I,D,I. Each rvalid goes only to the owner, RD_LAT cycles after its grant, with no overlap.
- d_req write addr=0x10, wdata=0xDEADBEEF, wmask=0xF, then fetch read 0x10 -> mem_we pulse in the grant cycle, then i_rdata=0xDEADBEEF.
- RD_LAT=3, back-to-back fetches at 0x0 and 0x4 -> grants at cycles 0 and 3, rvalids at cycles 3 and 6, mem_en exactly 2 pulses.
- d_addr=0x6 read, and separately d_addr=0x6 write -> mem_en=0 throughout; d_rvalid=1, d_err=1, d_rdata=0 one cycle after d_gnt.
- RD_LAT=2, reset asserted the cycle after a fetch grant -> no i_rvalid ever. The next conflicting request pair is granted to fetch first.
